// File: rtl/riscv_irq_pkg.sv
// Shared constants and types for the interrupt front end feeding the RISC-V core.
package riscv_irq_pkg;

  // Number of maskable interrupt lines and the width of an interrupt index.
  localparam int NUM_IRQ  = 8;
  localparam int IRQ_ID_W = $clog2(NUM_IRQ);

  // Synchroniser depth used when the instantiating level does not override it.
  localparam int SYNC_STAGES_DEF = 2;

  // Per-line trigger mode encoding used in EDGE_MODE vectors.
  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

  // Default trigger modes and reset values.
  localparam logic [NUM_IRQ-1:0] EDGE_MODE_DEF = 8'hFF;
  localparam logic [NUM_IRQ-1:0] MASK_RST_DEF  = 8'hFF;
  localparam logic               GIE_RST       = 1'b0;

  // Architectural state of the IRQ bank that advances together every cycle.
  typedef struct packed {
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] ovf;
  } irq_bank_t;

  // One-hot decode of the acknowledge handshake; an out-of-range id selects nothing.
  function automatic logic [NUM_IRQ-1:0] ack_decode(
    input logic                valid,
    input logic [IRQ_ID_W-1:0] id
  );
    logic [NUM_IRQ-1:0] dec;
    dec = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (valid && (int'(id) == i)) begin
        dec[i] = 1'b1;
      end else begin
        dec[i] = 1'b0;
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line plus a history flop
// that turns a synchronised 0->1 transition into a single-cycle pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_level,
  output logic rise_pulse
);

  // Chain of SYNC_STAGES flops; bit 0 is the metastability-exposed stage.
  logic [SYNC_STAGES-1:0] sync_chain_r;
  // Previous synchronised value, used to detect the rising edge.
  logic                   hist_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], async_in};
    end
  end

  // Remember last cycle's synchronised level; cleared on reset so a line
  // held high across reset release is seen as a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= sync_chain_r[SYNC_STAGES-1];
    end
  end

  assign sync_level = sync_chain_r[SYNC_STAGES-1];
  assign rise_pulse = sync_chain_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/irq_front_end.sv
// Interrupt front end: synchronises external IRQ/NMI lines, keeps per-line
// pending, mask and overflow state, and presents en_inter/int_req/nmi to the core.
module irq_front_end
  import riscv_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = riscv_irq_pkg::NUM_IRQ,
  parameter int                 SYNC_STAGES = riscv_irq_pkg::SYNC_STAGES_DEF,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE   = riscv_irq_pkg::EDGE_MODE_DEF,
  parameter logic [NUM_IRQ-1:0] MASK_RST    = riscv_irq_pkg::MASK_RST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                nmi_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic                gie_we,
  input  logic                gie_wdata,
  input  logic                ack_valid,
  input  logic [IRQ_ID_W-1:0] ack_id,
  input  logic                nmi_ack,
  output logic                en_inter,
  output logic [NUM_IRQ-1:0]  int_req,
  output logic                nmi,
  output logic [NUM_IRQ-1:0]  irq_ovf
);

  // Synchronised levels and rising-edge pulses of the IRQ lines.
  logic [NUM_IRQ-1:0] irq_lvl_s;
  logic [NUM_IRQ-1:0] irq_rise_s;
  logic               nmi_lvl_s;
  logic               nmi_rise_s;

  // Architectural registers.
  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] ovf_r;
  logic [NUM_IRQ-1:0] mask_r;
  logic               gie_r;
  logic               nmi_r;

  // Next-state values.
  logic [NUM_IRQ-1:0] ack_vec_s;
  logic [NUM_IRQ-1:0] pend_edge_next_s;
  logic [NUM_IRQ-1:0] ovf_evt_s;
  logic [NUM_IRQ-1:0] pending_next_s;
  logic [NUM_IRQ-1:0] ovf_next_s;
  logic [NUM_IRQ-1:0] mask_next_s;
  logic               gie_next_s;
  logic               nmi_set_s;
  logic               nmi_next_s;

  // One synchroniser + edge detector per maskable line.
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (irq_in[g]),
      .sync_level (irq_lvl_s[g]),
      .rise_pulse (irq_rise_s[g])
    );
  end

  // The NMI line always uses its rising edge.
  irq_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_nmi_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (nmi_in),
    .sync_level (nmi_lvl_s),
    .rise_pulse (nmi_rise_s)
  );

  // Decode the acknowledge handshake into a per-line clear vector.
  always_comb begin
    ack_vec_s = {NUM_IRQ{1'b0}};
    if (ack_valid) begin
      ack_vec_s = ack_decode(ack_valid, ack_id);
    end else begin
      ack_vec_s = {NUM_IRQ{1'b0}};
    end
  end

  // Pending and overflow next state: edge lines latch and are cleared by ack
  // (a new edge beats a simultaneous clear); level lines follow the synced level.
  always_comb begin
    pend_edge_next_s = irq_rise_s | (pending_r & ~ack_vec_s);
    ovf_evt_s        = EDGE_MODE & irq_rise_s & pending_r & ~ack_vec_s;
    pending_next_s   = (EDGE_MODE & pend_edge_next_s) | (~EDGE_MODE & irq_lvl_s);
    ovf_next_s       = ovf_evt_s | (ovf_r & ~ack_vec_s);
  end

  // Mask and global-enable write ports; values become visible next cycle.
  always_comb begin
    if (mask_we) begin
      mask_next_s = mask_wdata;
    end else begin
      mask_next_s = mask_r;
    end
    if (gie_we) begin
      gie_next_s = gie_wdata;
    end else begin
      gie_next_s = gie_r;
    end
  end

  // NMI is unmaskable; a new edge wins over a simultaneous acknowledge.
  // The rise pulse already implies a high synced level, the extra term is redundant.
  always_comb begin
    nmi_set_s = nmi_rise_s & nmi_lvl_s;
    if (nmi_set_s) begin
      nmi_next_s = 1'b1;
    end else if (nmi_ack) begin
      nmi_next_s = 1'b0;
    end else begin
      nmi_next_s = nmi_r;
    end
  end

  // State register: reset discards all pending state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NUM_IRQ{1'b0}};
      ovf_r     <= {NUM_IRQ{1'b0}};
      mask_r    <= MASK_RST;
      gie_r     <= GIE_RST;
      nmi_r     <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      ovf_r     <= ovf_next_s;
      mask_r    <= mask_next_s;
      gie_r     <= gie_next_s;
      nmi_r     <= nmi_next_s;
    end
  end

  // Outputs come straight from registers; int_req is a plain AND of two
  // registers so it cannot glitch, and en_inter does not gate it.
  assign int_req  = pending_r & mask_r;
  assign irq_ovf  = ovf_r;
  assign nmi      = nmi_r;
  assign en_inter = gie_r;

endmodule

// File: tb/tb_irq_front_end.sv
// Self-checking bench for irq_front_end: directed scenarios with literal
// expectations plus randomised traffic checked every cycle against a
// rule-level model of pending/mask/overflow/NMI behaviour.
module tb_irq_front_end;

  localparam logic [7:0] EM = 8'h7F;   // line 7 level-triggered, others edge
  localparam logic [7:0] MR = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       nmi_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       gie_we;
  logic       gie_wdata;
  logic       ack_valid;
  logic [2:0] ack_id;
  logic       nmi_ack;
  logic       en_inter;
  logic [7:0] int_req;
  logic       nmi;
  logic [7:0] irq_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_front_end #(
    .NUM_IRQ(8), .SYNC_STAGES(2), .EDGE_MODE(EM), .MASK_RST(MR)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .nmi_in(nmi_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .gie_we(gie_we), .gie_wdata(gie_wdata),
    .ack_valid(ack_valid), .ack_id(ack_id), .nmi_ack(nmi_ack),
    .en_inter(en_inter), .int_req(int_req), .nmi(nmi), .irq_ovf(irq_ovf)
  );

  // Model state: architectural registers plus the last three sampled input
  // vectors (bit 8 = NMI). A line's input is seen by the logic two edges
  // after it is sampled, and compared with the value one edge older.
  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] ovf;
    logic       gie;
    logic       nmi;
    logic [8:0] d0;
    logic [8:0] d1;
    logic [8:0] d2;
  } mstate_t;

  mstate_t m;
  bit      m_valid = 1'b0;

  function automatic mstate_t model_step(
    input mstate_t s, input logic r, input logic [7:0] irq, input logic nmi_i,
    input logic mwe, input logic [7:0] mwd, input logic gwe, input logic gwd,
    input logic av, input logic [2:0] aid, input logic nack);
    mstate_t    n;
    logic       rise;
    logic       acked;
    logic [7:0] em;
    em = EM;
    n  = s;
    if (r) begin
      n      = '0;
      n.mask = MR;
      return n;
    end
    for (int i = 0; i < 8; i++) begin
      rise  = s.d1[i] && !s.d2[i];
      acked = av && (aid == 3'(i));
      if (!em[i]) begin
        n.pend[i] = s.d1[i];
      end else if (acked) begin
        n.pend[i] = rise;
        n.ovf[i]  = 1'b0;
      end else if (rise) begin
        if (s.pend[i]) n.ovf[i] = 1'b1;
        n.pend[i] = 1'b1;
      end
    end
    if (s.d1[8] && !s.d2[8]) n.nmi = 1'b1;
    else if (nack)           n.nmi = 1'b0;
    if (mwe) n.mask = mwd;
    if (gwe) n.gie  = gwd;
    n.d2 = s.d1;
    n.d1 = s.d0;
    n.d0 = {nmi_i, irq};
    return n;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance the reference model on every active edge.
  always @(posedge clk) begin
    m <= model_step(m, rst, irq_in, nmi_in, mask_we, mask_wdata, gie_we, gie_wdata,
                    ack_valid, ack_id, nmi_ack);
    if (rst) m_valid <= 1'b1;
  end

  // Compare every output against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_int_req",  int_req,          m.pend & m.mask);
      check("model_irq_ovf",  irq_ovf,          m.ovf);
      check("model_nmi",      {7'd0, nmi},      {7'd0, m.nmi});
      check("model_en_inter", {7'd0, en_inter}, {7'd0, m.gie});
    end
  end

  initial begin
    rst = 1'b1; irq_in = 8'h00; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
    gie_we = 1'b0; gie_wdata = 1'b0; ack_valid = 1'b0; ack_id = 3'd0; nmi_ack = 1'b0;

    // 1. reset
    step(2);
    check("rst_int_req",  int_req,          8'h00);
    check("rst_nmi",      {7'd0, nmi},      8'h00);
    check("rst_en_inter", {7'd0, en_inter}, 8'h00);
    check("rst_irq_ovf",  irq_ovf,          8'h00);
    rst = 1'b0;
    step(2);

    // 2. edge latency on line 3, then ack
    irq_in[3] = 1'b1; step(1); irq_in[3] = 1'b0;
    step(1); check("lat_e2", int_req, 8'h00);
    step(1); check("lat_e3", int_req, 8'h08);
    check("lat_model", m.pend & m.mask, 8'h08);
    step(2); check("lat_hold", int_req, 8'h08);
    ack_valid = 1'b1; ack_id = 3'd3; step(1); ack_valid = 1'b0;
    check("ack3_clear", int_req, 8'h00);

    // 3. ack collision and overflow on line 5
    irq_in[5] = 1'b1; step(1); irq_in[5] = 1'b0; step(2);
    check("l5_pending", int_req, 8'h20);
    irq_in[5] = 1'b1; step(1); irq_in[5] = 1'b0; step(1);
    ack_valid = 1'b1; ack_id = 3'd5; step(1); ack_valid = 1'b0;
    check("coll_int_req", int_req, 8'h20);
    check("coll_ovf",     irq_ovf, 8'h00);
    irq_in[5] = 1'b1; step(1); irq_in[5] = 1'b0; step(2);
    check("ovf_set",   irq_ovf, 8'h20);
    check("ovf_model", m.ovf,   8'h20);
    check("ovf_req",   int_req, 8'h20);
    ack_valid = 1'b1; ack_id = 3'd5; step(1); ack_valid = 1'b0;
    check("ovf_ack_req", int_req, 8'h00);
    check("ovf_ack_ovf", irq_ovf, 8'h00);

    // 4. mask with level line 7
    mask_we = 1'b1; mask_wdata = 8'h00; step(1); mask_we = 1'b0;
    irq_in[7] = 1'b1; step(3);
    check("masked", int_req, 8'h00);
    mask_we = 1'b1; mask_wdata = 8'hFF; step(1); mask_we = 1'b0;
    check("unmask", int_req, 8'h80);
    ack_valid = 1'b1; ack_id = 3'd7; step(1); ack_valid = 1'b0;
    check("lvl_ack_ignored", int_req, 8'h80);
    irq_in[7] = 1'b0; step(2);
    check("lvl_drop_e2", int_req, 8'h80);
    step(1);
    check("lvl_drop_e3", int_req, 8'h00);

    // 5. GIE and NMI
    gie_we = 1'b1; gie_wdata = 1'b1; step(1); gie_we = 1'b0;
    check("gie_set", {7'd0, en_inter}, 8'h01);
    gie_we = 1'b1; gie_wdata = 1'b0; mask_we = 1'b1; mask_wdata = 8'h00;
    step(1); gie_we = 1'b0; mask_we = 1'b0;
    check("gie_clr", {7'd0, en_inter}, 8'h00);
    nmi_in = 1'b1; step(2);
    check("nmi_e2", {7'd0, nmi}, 8'h00);
    step(1);
    check("nmi_e3", {7'd0, nmi}, 8'h01);
    nmi_ack = 1'b1; step(1); nmi_ack = 1'b0;
    check("nmi_ack", {7'd0, nmi}, 8'h00);
    step(4);
    check("nmi_no_refire", {7'd0, nmi}, 8'h00);
    nmi_in = 1'b0; step(3);

    // 6. reset mid-operation (mask currently 0, so re-fire shows reset mask)
    gie_we = 1'b1; gie_wdata = 1'b1; irq_in = 8'hFF; nmi_in = 1'b1;
    step(1); gie_we = 1'b0; step(3);
    check("pre_rst_model_pend", m.pend, 8'hFF);
    check("pre_rst_nmi", {7'd0, nmi}, 8'h01);
    rst = 1'b1; step(1); rst = 1'b0;
    check("mid_rst_int_req",  int_req,          8'h00);
    check("mid_rst_nmi",      {7'd0, nmi},      8'h00);
    check("mid_rst_en_inter", {7'd0, en_inter}, 8'h00);
    check("mid_rst_ovf",      irq_ovf,          8'h00);
    step(2);
    check("refire_e2", int_req, 8'h00);
    step(1);
    check("refire_e3", int_req, 8'hFF);
    check("refire_nmi", {7'd0, nmi}, 8'h01);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(3, 0) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(7, 0) == 0) nmi_in = ~nmi_in;
      mask_we    = ($urandom_range(15, 0) == 0);
      mask_wdata = 8'($urandom);
      gie_we     = ($urandom_range(15, 0) == 0);
      gie_wdata  = 1'($urandom);
      ack_valid  = ($urandom_range(2, 0) == 0);
      ack_id     = 3'($urandom_range(7, 0));
      nmi_ack    = ($urandom_range(5, 0) == 0);
      rst        = ($urandom_range(255, 0) == 0);
      step(1);
    end
    rst = 1'b0; ack_valid = 1'b0; nmi_ack = 1'b0; mask_we = 1'b0; gie_we = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
